// File: rtl/stopwatch_display_controller.sv
// stopwatch_display_controller: debounced buttons drive an MM:SS BCD stopwatch with lap freeze
module stopwatch_display_controller #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btnU,
  input  logic        btnR,
  input  logic        btnL,
  output logic [3:0]  sec_dig1,
  output logic [3:0]  sec_dig2,
  output logic [3:0]  min_dig1,
  output logic [3:0]  min_dig2,
  output logic        running,
  output logic [15:0] led
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  typedef enum logic [3:0] {IDLE = 4'b0001, RUN = 4'b0010, PAUSE = 4'b0100, LAP = 4'b1000} state_t;
  state_t state, nstate;
  logic [2:0] sync1, sync2, acc, acc_d, pulse;
  logic [DW-1:0] db_cnt [3];
  logic [PW-1:0] presc, presc_n;
  logic [15:0] cnt, cnt_n, snap, snap_n, inc;
  logic pu, pr, pl, counting, tick, clr, w_s1, w_s2, w_m1, w_m2;
  // bit 0 = U, bit 1 = R, bit 2 = L
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      acc <= '0;
      acc_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {btnL, btnR, btnU};
      sync2 <= sync1;
      acc_d <= acc;
      for (int i = 0; i < 3; i++)
        if (sync2[i] == acc[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] == DW'(DB_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          acc[i] <= sync2[i];
        end else db_cnt[i] <= db_cnt[i] + DW'(1);
    end
  assign pulse = acc & ~acc_d;
  assign pu = pulse[0];
  assign pr = pulse[1] & ~pulse[0];
  assign pl = pulse[2] & ~|pulse[1:0];
  always_comb begin
    counting = state == RUN || state == LAP;
    tick = counting && presc == PW'(TICK_DIV - 1);
    w_s1 = cnt[3:0] >= 4'd9;
    w_s2 = w_s1 && cnt[7:4] >= 4'd5;
    w_m1 = w_s2 && cnt[11:8] >= 4'd9;
    w_m2 = w_m1 && cnt[15:12] >= 4'd5;
    inc = {w_m2 ? 4'd0 : w_m1 ? cnt[15:12] + 4'd1 : cnt[15:12],
           w_m1 ? 4'd0 : w_s2 ? cnt[11:8] + 4'd1 : cnt[11:8],
           w_s2 ? 4'd0 : w_s1 ? cnt[7:4] + 4'd1 : cnt[7:4],
           w_s1 ? 4'd0 : cnt[3:0] + 4'd1};
    nstate = state == IDLE  ? (pu ? RUN : IDLE) :
             state == RUN   ? (pu ? PAUSE : pr ? LAP : RUN) :
             state == LAP   ? (pu ? PAUSE : pr ? RUN : LAP) :
             state == PAUSE ? (pu ? RUN : pl ? IDLE : PAUSE) : IDLE;
    clr = state == PAUSE && !pu && pl;
    cnt_n = clr ? 16'd0 : tick ? inc : cnt;
    snap_n = (state == RUN && !pu && pr) ? cnt : snap;
    presc_n = clr ? '0 : !counting ? presc : tick ? '0 : presc + PW'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      presc <= '0;
      cnt <= '0;
      snap <= '0;
      {min_dig2, min_dig1, sec_dig2, sec_dig1} <= '0;
      running <= 1'b0;
      led <= 16'h0001;
    end else begin
      state <= nstate;
      presc <= presc_n;
      cnt <= cnt_n;
      snap <= snap_n;
      {min_dig2, min_dig1, sec_dig2, sec_dig1} <= nstate == LAP ? snap_n : cnt_n;
      running <= nstate == RUN || nstate == LAP;
      led <= {clr ? 1'b0 : led[15] | (tick & w_m2), 11'd0, nstate};
    end
endmodule
